// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : adder_pkg
//  Purpose : Shared definitions for the bit-serial adder/subtractor.
//            Holds the controller state encoding and a small helper function.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package adder_pkg;

  // Controller states. The encoding is fixed so the state register
  // has the same values in every build.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Operand B as seen by the adder: the one's complement of B when
  // subtracting. The +1 of the two's complement comes in as the
  // initial carry.
  function automatic logic [63:0] cond_invert(input logic [63:0] val, input logic inv);
    return inv ? ~val : val;
  endfunction

endpackage : adder_pkg
`default_nettype wire

// File: rtl/fa_cell.sv
`default_nettype none
// ============================================================================
//  Module  : fa_cell
//  Purpose : Gate-level 1-bit full adder built from two half adders.
//            This is the only arithmetic element in the serial datapath.
//  Ports   : x, y, z  in  1  addend bits and carry-in
//            sum      out 1  x ^ y ^ z
//            carry    out 1  majority(x, y, z)
//  Rev     : 1.0  initial release
// ============================================================================
module fa_cell (
  output logic sum,
  output logic carry,
  input  logic x,
  input  logic y,
  input  logic z
);

  logic ha0_s;
  logic ha0_c;
  logic ha1_c;

  // First half adder: x + y
  assign ha0_s = x ^ y;
  assign ha0_c = x & y;

  // Second half adder: partial sum + carry-in
  assign sum   = ha0_s ^ z;
  assign ha1_c = ha0_s & z;

  // The two half-adder carries can never both be 1, so an OR merges them.
  assign carry = ha0_c | ha1_c;

endmodule : fa_cell
`default_nettype wire

// File: rtl/serial_add_sub.sv
`default_nettype none
// ============================================================================
//  Module  : serial_add_sub
//  Purpose : Bit-serial WIDTH-bit adder/subtractor. Processes one bit per
//            clock, LSB first, using one full-adder cell and one carry flop.
//            A start/busy/done handshake frames each operation. The module
//            returns the carry out of the MSB and the signed-overflow flag.
//  Ports   : clk     in  1      rising-edge clock
//            rst_n   in  1      asynchronous active-low reset
//            start   in  1      operation request, sampled only in IDLE
//            sub     in  1      0: a+b, 1: a-b (sampled with start)
//            a, b    in  WIDTH  operands (sampled with start)
//            busy    out 1      high while an operation is in progress
//            done    out 1      one-cycle pulse; result/cout/ovf valid
//            result  out WIDTH  sum or difference, modulo 2^WIDTH
//            cout    out 1      carry out of MSB (sub: 1 = no borrow)
//            ovf     out 1      signed overflow
//  Rev     : 1.0  initial release
// ============================================================================
module serial_add_sub
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic               carry_q,  carry_d;
  logic [WIDTH-1:0]   a_sh_q,   a_sh_d;
  logic [WIDTH-1:0]   b_sh_q,   b_sh_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q,   cout_d;
  logic               ovf_q,    ovf_d;

  logic               bit_sum;
  logic               bit_carry;
  logic [WIDTH-1:0]   b_eff;

  // Serial bit slice: the current LSBs of both shift registers plus the
  // stored carry.
  fa_cell u_fa (
    .sum   (bit_sum),
    .carry (bit_carry),
    .x     (a_sh_q[0]),
    .y     (b_sh_q[0]),
    .z     (carry_q)
  );

  assign b_eff = WIDTH'(cond_invert(64'(b), sub));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b_eff;
          carry_d = sub;        // +1 that completes -b in two's complement
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d  = bit_carry;
        // Each new sum bit enters at the MSB. After WIDTH shifts, bit 0
        // has reached the LSB.
        result_d = {bit_sum, result_q[WIDTH-1:1]};
        if (cnt_q == CNT_LAST) begin
          // carry_q is the carry into the MSB here; bit_carry is the
          // carry out of the MSB.
          cout_d  = bit_carry;
          ovf_d   = carry_q ^ bit_carry;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Both flags decode only the state register, so no input reaches them
  // through combinational logic.
  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule : serial_add_sub
`default_nettype wire

// File: tb/tb_serial_add_sub.sv
`default_nettype none
// ============================================================================
//  Module  : tb_serial_add_sub
//  Purpose : Directed self-checking bench for serial_add_sub at WIDTH 8,
//            2 and 16, with a small arithmetic reference model for the
//            WIDTH 2 and WIDTH 16 sweeps.
//  Ports   : none
//  Rev     : 1.0  initial release
// ============================================================================
module tb_serial_add_sub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sub_in = 1'b0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic        start8 = 1'b0;
  logic        start2 = 1'b0;
  logic        start16 = 1'b0;

  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  res8;
  logic        busy2, done2, cout2, ovf2;
  logic [1:0]  res2;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] res16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub_in),
    .a(a_in[7:0]), .b(b_in[7:0]), .busy(busy8), .done(done8),
    .result(res8), .cout(cout8), .ovf(ovf8)
  );

  serial_add_sub #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub_in),
    .a(a_in[1:0]), .b(b_in[1:0]), .busy(busy2), .done(done2),
    .result(res2), .cout(cout2), .ovf(ovf2)
  );

  serial_add_sub #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub_in),
    .a(a_in), .b(b_in), .busy(busy16), .done(done16),
    .result(res16), .cout(cout16), .ovf(ovf16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic obs_busy(input int w);
    return (w == 2) ? busy2 : (w == 16) ? busy16 : busy8;
  endfunction

  function automatic logic obs_done(input int w);
    return (w == 2) ? done2 : (w == 16) ? done16 : done8;
  endfunction

  function automatic logic [15:0] obs_res(input int w);
    return (w == 2) ? {14'd0, res2} : (w == 16) ? res16 : {8'd0, res8};
  endfunction

  function automatic logic obs_cout(input int w);
    return (w == 2) ? cout2 : (w == 16) ? cout16 : cout8;
  endfunction

  function automatic logic obs_ovf(input int w);
    return (w == 2) ? ovf2 : (w == 16) ? ovf16 : ovf8;
  endfunction

  // Reference: wide integer add; overflow from operand/result sign rule.
  task automatic model(input int w, input logic s, input logic [15:0] av, input logic [15:0] bv,
                       output logic [15:0] r, output logic c, output logic o);
    logic [16:0] mask;
    logic [16:0] bb;
    logic [16:0] full;
    mask = (17'd1 << w) - 17'd1;
    bb   = s ? (~{1'b0, bv} & mask) : ({1'b0, bv} & mask);
    full = ({1'b0, av} & mask) + bb + {16'd0, s};
    r    = full[15:0] & mask[15:0];
    c    = full[w];
    o    = (av[w-1] == bb[w-1]) && (r[w-1] != av[w-1]);
  endtask

  // One full operation on the selected instance, checking latency,
  // done width, results and the hold in IDLE.
  task automatic run_op(input int w, input logic s, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] er, input logic ec, input logic eo, input string tag);
    int n;
    @(negedge clk);
    sub_in  = s;
    a_in    = av;
    b_in    = bv;
    start2  = (w == 2);
    start8  = (w == 8);
    start16 = (w == 16);
    @(negedge clk);
    start2 = 1'b0; start8 = 1'b0; start16 = 1'b0;
    chk({tag, " busy"}, 32'(obs_busy(w)), 32'd1);
    n = 0;
    while (obs_done(w) !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(w));
    chk({tag, " result"}, 32'(obs_res(w)), 32'(er));
    chk({tag, " cout"}, 32'(obs_cout(w)), 32'(ec));
    chk({tag, " ovf"}, 32'(obs_ovf(w)), 32'(eo));
    @(negedge clk);
    chk({tag, " done width"}, 32'(obs_done(w)), 32'd0);
    chk({tag, " idle"}, 32'(obs_busy(w)), 32'd0);
    chk({tag, " hold"}, 32'(obs_res(w)), 32'(er));
  endtask

  initial begin
    logic [15:0] er;
    logic        ec;
    logic        eo;
    logic        saw_done;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rs;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy8), 32'd0);
    chk("reset done", 32'(done8), 32'd0);
    chk("reset result", 32'(res8), 32'd0);
    chk("reset cout", 32'(cout8), 32'd0);
    chk("reset ovf", 32'(ovf8), 32'd0);
    rst_n = 1'b1;

    // WIDTH=8 directed vectors
    run_op(8, 1'b0, 16'h3C, 16'h05, 16'h41, 1'b0, 1'b0, "add 3C+05");
    run_op(8, 1'b0, 16'hFF, 16'h01, 16'h00, 1'b1, 1'b0, "add FF+01");
    run_op(8, 1'b0, 16'h7F, 16'h01, 16'h80, 1'b0, 1'b1, "add 7F+01");
    run_op(8, 1'b1, 16'h05, 16'h07, 16'hFE, 1'b0, 1'b0, "sub 05-07");
    run_op(8, 1'b1, 16'h80, 16'h01, 16'h7F, 1'b1, 1'b1, "sub 80-01");

    // Start re-pulsed during RUN and DONE with different operands
    @(negedge clk);
    sub_in = 1'b0; a_in = 16'h3C; b_in = 16'h05; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    sub_in = 1'b1; a_in = 16'hFF; b_in = 16'hFF; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk("ignore run busy", 32'(busy8), 32'd1);
    begin
      int n;
      n = 0;
      while (done8 !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("ignore latency", 32'(n), 32'd5);
    end
    chk("ignore result", 32'(res8), 32'h41);
    chk("ignore cout", 32'(cout8), 32'd0);
    start8 = 1'b1; a_in = 16'h11; b_in = 16'h22;
    @(negedge clk);
    chk("ignore done-start", 32'(busy8), 32'd0);
    chk("ignore held", 32'(res8), 32'h41);
    start8 = 1'b0;

    // Reset asserted mid-operation
    @(negedge clk);
    sub_in = 1'b0; a_in = 16'hFF; b_in = 16'hFF; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(busy8), 32'd0);
    chk("abort done", 32'(done8), 32'd0);
    chk("abort result", 32'(res8), 32'd0);
    chk("abort cout", 32'(cout8), 32'd0);
    chk("abort ovf", 32'(ovf8), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done8 === 1'b1 || busy8 === 1'b1) saw_done = 1'b1;
    end
    chk("abort no done", 32'(saw_done), 32'd0);
    run_op(8, 1'b0, 16'h10, 16'h20, 16'h30, 1'b0, 1'b0, "add 10+20");

    // WIDTH=2 exhaustive against the reference model
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 4; x++) begin
        for (int y = 0; y < 4; y++) begin
          model(2, s[0], 16'(x), 16'(y), er, ec, eo);
          run_op(2, s[0], 16'(x), 16'(y), er, ec, eo, "w2");
        end
      end
    end

    // WIDTH=16 hand vectors plus random ops
    run_op(16, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, "w16 add wrap");
    run_op(16, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, "w16 sub ovf");
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      model(16, rs, ra, rb, er, ec, eo);
      run_op(16, rs, ra, rb, er, ec, eo, "w16 rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_serial_add_sub
`default_nettype wire
